// File: rtl/fetch_decode_exec.sv
// fetch_decode_exec: single-cycle RV64I slice covering fetch, decode and ALU.
// The only state is a fetch-valid flag. While that flag is low the stage
// issues addi x0,x0,0 in place of the instruction memory data. Everything
// else is combinational. An undecodable word is turned into that same NOP,
// except that its rd write enable is forced low and o_illegal is raised.
module fetch_decode_exec #(
  parameter int CPU_WIDTH     = 64,
  parameter int REG_ADDRW     = 5,
  parameter int EXU_OPT_WIDTH = 5,
  parameter int EXU_SEL_WIDTH = 2,
  parameter int LSU_OPT_WIDTH = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CPU_WIDTH-1:0]     i_pc,
  output logic [CPU_WIDTH-1:0]     o_imem_addr,
  input  logic [31:0]              i_imem_rdata,
  output logic [31:0]              o_ins,
  output logic [REG_ADDRW-1:0]     o_rs1id,
  output logic [REG_ADDRW-1:0]     o_rs2id,
  output logic [REG_ADDRW-1:0]     o_rdid,
  output logic                     o_rdwen,
  input  logic [CPU_WIDTH-1:0]     i_rs1,
  input  logic [CPU_WIDTH-1:0]     i_rs2,
  output logic [CPU_WIDTH-1:0]     o_imm,
  output logic [EXU_SEL_WIDTH-1:0] o_exu_src_sel,
  output logic [EXU_OPT_WIDTH-1:0] o_exu_opt,
  output logic [LSU_OPT_WIDTH-1:0] o_lsu_opt,
  output logic                     o_brch,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic [CPU_WIDTH-1:0]     o_exu_res,
  output logic                     o_zero,
  output logic                     o_ebreak,
  output logic                     o_illegal
);

  localparam logic [31:0] INS_NOP    = 32'h0000_0013;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_RS2 = 2'b00;
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_IMM = 2'b01;
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_IMM  = 2'b10;
  localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_4    = 2'b11;

  localparam logic [EXU_OPT_WIDTH-1:0] OPT_ADD  = 5'd0;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SUB  = 5'd1;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLL  = 5'd2;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLT  = 5'd3;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLTU = 5'd4;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_XOR  = 5'd5;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRL  = 5'd6;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRA  = 5'd7;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_OR   = 5'd8;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_AND  = 5'd9;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_ADDW = 5'd10;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SUBW = 5'd11;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SLLW = 5'd12;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRLW = 5'd13;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_SRAW = 5'd14;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BEQ  = 5'd15;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BNE  = 5'd16;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BLT  = 5'd17;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BGE  = 5'd18;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BLTU = 5'd19;
  localparam logic [EXU_OPT_WIDTH-1:0] OPT_BGEU = 5'd20;

  localparam logic [LSU_OPT_WIDTH-1:0] LSU_NONE = 5'b00001;

  // ---------------------------------------------------------------- fetch
  logic fetch_vld_q;
  logic fetch_vld_d;

  assign fetch_vld_d = 1'b1;

  // Fetch-valid flag: held low during reset, high from the first edge after release
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_vld_q <= 1'b0;
    end else begin
      fetch_vld_q <= fetch_vld_d;
    end
  end

  logic [31:0] ins;
  assign ins         = fetch_vld_q ? i_imem_rdata : INS_NOP;
  assign o_ins       = ins;
  assign o_imem_addr = i_pc;
  assign o_ebreak    = (ins == INS_EBREAK);

  // --------------------------------------------------------------- decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  logic [CPU_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(CPU_WIDTH-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(CPU_WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(CPU_WIDTH-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(CPU_WIDTH-32){ins[31]}}, ins[31:12], 12'h000};
  assign imm_j = {{(CPU_WIDTH-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  logic                     dec_legal;
  logic [REG_ADDRW-1:0]     dec_rs1id;
  logic                     dec_rdwen;
  logic [CPU_WIDTH-1:0]     dec_imm;
  logic [EXU_SEL_WIDTH-1:0] dec_sel;
  logic [EXU_OPT_WIDTH-1:0] dec_opt;
  logic [LSU_OPT_WIDTH-1:0] dec_lsu;
  logic                     dec_brch, dec_jal, dec_jalr;

  // Instruction decode: classify the opcode and derive operand/ALU/LSU controls
  always_comb begin
    dec_legal = 1'b0;
    dec_rs1id = ins[19:15];
    dec_rdwen = 1'b0;
    dec_imm   = '0;
    dec_sel   = SEL_RS1_IMM;
    dec_opt   = OPT_ADD;
    dec_lsu   = LSU_NONE;
    dec_brch  = 1'b0;
    dec_jal   = 1'b0;
    dec_jalr  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_rdwen = 1'b1;
        dec_rs1id = '0;
        dec_imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_rdwen = 1'b1;
        dec_imm   = imm_u;
        dec_sel   = SEL_PC_IMM;
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        dec_rdwen = 1'b1;
        dec_imm   = imm_j;
        dec_sel   = SEL_PC_4;
        dec_jal   = 1'b1;
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000);
        dec_rdwen = 1'b1;
        dec_imm   = imm_i;
        dec_sel   = SEL_PC_4;
        dec_jalr  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_legal = 1'b1;
        dec_imm   = imm_b;
        dec_sel   = SEL_RS1_RS2;
        dec_brch  = 1'b1;
        case (funct3)
          3'b000:  dec_opt = OPT_BEQ;
          3'b001:  dec_opt = OPT_BNE;
          3'b100:  dec_opt = OPT_BLT;
          3'b101:  dec_opt = OPT_BGE;
          3'b110:  dec_opt = OPT_BLTU;
          3'b111:  dec_opt = OPT_BGEU;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_legal = (funct3 != 3'b111);
        dec_rdwen = 1'b1;
        dec_imm   = imm_i;
        dec_lsu   = {funct3, 2'b00};
      end
      OPC_STORE: begin
        dec_legal = (funct3[2] == 1'b0);
        dec_imm   = imm_s;
        dec_lsu   = {funct3, 2'b11};
      end
      OPC_OPIMM: begin
        dec_legal = 1'b1;
        dec_rdwen = 1'b1;
        dec_imm   = imm_i;
        case (funct3)
          3'b000:  dec_opt = OPT_ADD;
          3'b010:  dec_opt = OPT_SLT;
          3'b011:  dec_opt = OPT_SLTU;
          3'b100:  dec_opt = OPT_XOR;
          3'b110:  dec_opt = OPT_OR;
          3'b111:  dec_opt = OPT_AND;
          3'b001: begin
            dec_opt   = OPT_SLL;
            dec_legal = (ins[31:26] == 6'b000000);
          end
          3'b101: begin
            dec_opt   = ins[30] ? OPT_SRA : OPT_SRL;
            dec_legal = (ins[31] == 1'b0) && (ins[29:26] == 4'b0000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OPIMMW: begin
        dec_rdwen = 1'b1;
        dec_imm   = imm_i;
        case (funct3)
          3'b000: begin
            dec_opt   = OPT_ADDW;
            dec_legal = 1'b1;
          end
          3'b001: begin
            dec_opt   = OPT_SLLW;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_opt   = ins[30] ? OPT_SRAW : OPT_SRLW;
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec_rdwen = 1'b1;
        dec_sel   = SEL_RS1_RS2;
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000:  dec_opt = ins[30] ? OPT_SUB : OPT_ADD;
          3'b001:  dec_opt = OPT_SLL;
          3'b010:  dec_opt = OPT_SLT;
          3'b011:  dec_opt = OPT_SLTU;
          3'b100:  dec_opt = OPT_XOR;
          3'b101:  dec_opt = ins[30] ? OPT_SRA : OPT_SRL;
          3'b110:  dec_opt = OPT_OR;
          3'b111:  dec_opt = OPT_AND;
          default: dec_opt = OPT_ADD;
        endcase
      end
      OPC_OPW: begin
        dec_rdwen = 1'b1;
        dec_sel   = SEL_RS1_RS2;
        case (funct3)
          3'b000: begin
            dec_opt   = ins[30] ? OPT_SUBW : OPT_ADDW;
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'b001: begin
            dec_opt   = OPT_SLLW;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_opt   = ins[30] ? OPT_SRAW : OPT_SRLW;
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        // Only ebreak is accepted; it reads x0 and adds zero so the result stays 0
        dec_legal = (ins == INS_EBREAK);
        dec_rs1id = '0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal words collapse onto the NOP controls with the rd write suppressed
  assign o_illegal     = ~dec_legal;
  assign o_rs1id       = dec_legal ? dec_rs1id : '0;
  assign o_rs2id       = dec_legal ? ins[24:20] : '0;
  assign o_rdid        = dec_legal ? ins[11:7] : '0;
  assign o_rdwen       = dec_legal & dec_rdwen;
  assign o_imm         = dec_legal ? dec_imm : '0;
  assign o_exu_src_sel = dec_legal ? dec_sel : SEL_RS1_IMM;
  assign o_exu_opt     = dec_legal ? dec_opt : OPT_ADD;
  assign o_lsu_opt     = dec_legal ? dec_lsu : LSU_NONE;
  assign o_brch        = dec_legal & dec_brch;
  assign o_jal         = dec_legal & dec_jal;
  assign o_jalr        = dec_legal & dec_jalr;

  // ------------------------------------------------------------------ ALU
  logic [CPU_WIDTH-1:0] op_a, op_b;
  assign op_a = o_exu_src_sel[1] ? i_pc : i_rs1;
  assign op_b = (o_exu_src_sel == SEL_RS1_RS2) ? i_rs2 :
                (o_exu_src_sel == SEL_PC_4)    ? CPU_WIDTH'(4) : o_imm;

  logic [31:0] add_w, sub_w, sll_w, srl_w, sra_w;
  assign add_w = op_a[31:0] + op_b[31:0];
  assign sub_w = op_a[31:0] - op_b[31:0];
  assign sll_w = op_a[31:0] << op_b[4:0];
  assign srl_w = op_a[31:0] >> op_b[4:0];
  assign sra_w = $signed(op_a[31:0]) >>> op_b[4:0];

  logic cmp_eq, cmp_lt, cmp_ltu;
  assign cmp_eq  = (op_a == op_b);
  assign cmp_lt  = ($signed(op_a) < $signed(op_b));
  assign cmp_ltu = (op_a < op_b);

  logic [CPU_WIDTH-1:0] alu_res;

  // ALU: arithmetic/logic ops, W ops sign-extend bit 31, branches yield 0 when taken
  always_comb begin
    alu_res = '0;
    case (o_exu_opt)
      OPT_ADD:  alu_res = op_a + op_b;
      OPT_SUB:  alu_res = op_a - op_b;
      OPT_SLL:  alu_res = op_a << op_b[5:0];
      OPT_SLT:  alu_res = {{(CPU_WIDTH-1){1'b0}}, cmp_lt};
      OPT_SLTU: alu_res = {{(CPU_WIDTH-1){1'b0}}, cmp_ltu};
      OPT_XOR:  alu_res = op_a ^ op_b;
      OPT_SRL:  alu_res = op_a >> op_b[5:0];
      OPT_SRA:  alu_res = $signed(op_a) >>> op_b[5:0];
      OPT_OR:   alu_res = op_a | op_b;
      OPT_AND:  alu_res = op_a & op_b;
      OPT_ADDW: alu_res = {{(CPU_WIDTH-32){add_w[31]}}, add_w};
      OPT_SUBW: alu_res = {{(CPU_WIDTH-32){sub_w[31]}}, sub_w};
      OPT_SLLW: alu_res = {{(CPU_WIDTH-32){sll_w[31]}}, sll_w};
      OPT_SRLW: alu_res = {{(CPU_WIDTH-32){srl_w[31]}}, srl_w};
      OPT_SRAW: alu_res = {{(CPU_WIDTH-32){sra_w[31]}}, sra_w};
      OPT_BEQ:  alu_res = {{(CPU_WIDTH-1){1'b0}}, ~cmp_eq};
      OPT_BNE:  alu_res = {{(CPU_WIDTH-1){1'b0}}, cmp_eq};
      OPT_BLT:  alu_res = {{(CPU_WIDTH-1){1'b0}}, ~cmp_lt};
      OPT_BGE:  alu_res = {{(CPU_WIDTH-1){1'b0}}, cmp_lt};
      OPT_BLTU: alu_res = {{(CPU_WIDTH-1){1'b0}}, ~cmp_ltu};
      OPT_BGEU: alu_res = {{(CPU_WIDTH-1){1'b0}}, cmp_ltu};
      default:  alu_res = '0;
    endcase
  end

  assign o_exu_res = alu_res;
  assign o_zero    = (alu_res == '0);

endmodule

// File: tb/tb_fetch_decode_exec.sv
// Bench for fetch_decode_exec: directed cases plus randomized instruction
// words checked against an instruction-level reference model.
module tb_fetch_decode_exec;

  logic        clk;
  logic        rst;
  logic [63:0] i_pc;
  logic [63:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_ins;
  logic [4:0]  o_rs1id, o_rs2id, o_rdid;
  logic        o_rdwen;
  logic [63:0] i_rs1, i_rs2;
  logic [63:0] o_imm;
  logic [1:0]  o_exu_src_sel;
  logic [4:0]  o_exu_opt;
  logic [4:0]  o_lsu_opt;
  logic        o_brch, o_jal, o_jalr;
  logic [63:0] o_exu_res;
  logic        o_zero, o_ebreak, o_illegal;

  logic [63:0] rf [32];

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_decode_exec dut (
    .i_clk(clk), .i_rst(rst), .i_pc(i_pc), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .o_ins(o_ins),
    .o_rs1id(o_rs1id), .o_rs2id(o_rs2id), .o_rdid(o_rdid), .o_rdwen(o_rdwen),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .o_imm(o_imm), .o_exu_src_sel(o_exu_src_sel),
    .o_exu_opt(o_exu_opt), .o_lsu_opt(o_lsu_opt), .o_brch(o_brch), .o_jal(o_jal),
    .o_jalr(o_jalr), .o_exu_res(o_exu_res), .o_zero(o_zero), .o_ebreak(o_ebreak),
    .o_illegal(o_illegal)
  );

  // Register file seen by the stage: reads follow the decoded indices
  assign i_rs1 = rf[o_rs1id];
  assign i_rs2 = rf[o_rs2id];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    bit          use_rs1, use_rs2, chk_imm_res;
    bit          wen, brch, jal, jalr, ebreak, illegal;
    logic [63:0] imm, res;
    logic [1:0]  sel;
    logic [4:0]  opt, lsu;
  } exp_t;

  localparam logic [6:0] OPCS [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                      7'h23, 7'h13, 7'h1b, 7'h33, 7'h3b, 7'h73};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    longint t;
    t = longint'(int'(v));
    return t;
  endfunction

  // Instruction-level reference: what each RV64I instruction must produce
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a, b;
    bit          ok, taken;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = rf[ins[19:15]]; b = rf[ins[24:20]];
    e = '{rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20], use_rs1: 0, use_rs2: 0,
          chk_imm_res: 1, wen: 0, brch: 0, jal: 0, jalr: 0, ebreak: 0, illegal: 0,
          imm: 64'd0, res: 64'd0, sel: 2'b01, opt: 5'd0, lsu: 5'b00001};
    ok = 0; taken = 0;
    case (op)
      7'h37: begin ok = 1; e.wen = 1; e.imm = longint'($signed({ins[31:12], 12'h000}));
                   e.rs1 = 5'd0; e.use_rs1 = 1; e.res = e.imm; end
      7'h17: begin ok = 1; e.wen = 1; e.imm = longint'($signed({ins[31:12], 12'h000}));
                   e.sel = 2'b10; e.res = pc + e.imm; end
      7'h6f: begin ok = 1; e.wen = 1; e.jal = 1; e.sel = 2'b11; e.res = pc + 64'd4;
                   e.imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h67: if (f3 == 3'd0) begin
                   ok = 1; e.wen = 1; e.jalr = 1; e.sel = 2'b11; e.use_rs1 = 1;
                   e.imm = longint'($signed(ins[31:20])); e.res = pc + 64'd4; end
      7'h63: begin
        e.brch = 1; e.sel = 2'b00; e.use_rs1 = 1; e.use_rs2 = 1;
        e.imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ok = 1;
        case (f3)
          3'd0: begin e.opt = 5'd15; taken = (a == b); end
          3'd1: begin e.opt = 5'd16; taken = (a != b); end
          3'd4: begin e.opt = 5'd17; taken = ($signed(a) < $signed(b)); end
          3'd5: begin e.opt = 5'd18; taken = ($signed(a) >= $signed(b)); end
          3'd6: begin e.opt = 5'd19; taken = (a < b); end
          3'd7: begin e.opt = 5'd20; taken = (a >= b); end
          default: ok = 0;
        endcase
        e.res = taken ? 64'd0 : 64'd1;
      end
      7'h03: if (f3 != 3'd7) begin
                   ok = 1; e.wen = 1; e.use_rs1 = 1; e.imm = longint'($signed(ins[31:20]));
                   e.lsu = {f3, 2'b00}; e.res = a + e.imm; end
      7'h23: if (f3 < 3'd4) begin
                   ok = 1; e.use_rs1 = 1; e.use_rs2 = 1;
                   e.imm = longint'($signed({ins[31:25], ins[11:7]}));
                   e.lsu = {f3, 2'b11}; e.res = a + e.imm; end
      7'h13: begin
        e.wen = 1; e.use_rs1 = 1; e.imm = longint'($signed(ins[31:20])); ok = 1;
        case (f3)
          3'd0: e.res = a + e.imm;
          3'd2: begin e.opt = 5'd3; e.res = {63'd0, $signed(a) < $signed(e.imm)}; end
          3'd3: begin e.opt = 5'd4; e.res = {63'd0, a < e.imm}; end
          3'd4: begin e.opt = 5'd5; e.res = a ^ e.imm; end
          3'd6: begin e.opt = 5'd8; e.res = a | e.imm; end
          3'd7: begin e.opt = 5'd9; e.res = a & e.imm; end
          3'd1: begin ok = (ins[31:26] == 6'h00); e.opt = 5'd2; e.res = a << ins[25:20]; end
          default: begin
            if (ins[31:26] == 6'h00) begin e.opt = 5'd6; e.res = a >> ins[25:20]; end
            else if (ins[31:26] == 6'h10) begin e.opt = 5'd7; e.res = $signed(a) >>> ins[25:20]; end
            else ok = 0;
          end
        endcase
      end
      7'h1b: begin
        e.wen = 1; e.use_rs1 = 1; e.imm = longint'($signed(ins[31:20]));
        if (f3 == 3'd0) begin ok = 1; e.opt = 5'd10; e.res = sx32(a[31:0] + e.imm[31:0]); end
        else if (f3 == 3'd1 && f7 == 7'h00) begin ok = 1; e.opt = 5'd12; e.res = sx32(a[31:0] << ins[24:20]); end
        else if (f3 == 3'd5 && f7 == 7'h00) begin ok = 1; e.opt = 5'd13; e.res = sx32(a[31:0] >> ins[24:20]); end
        else if (f3 == 3'd5 && f7 == 7'h20) begin ok = 1; e.opt = 5'd14; e.res = sx32(int'(a[31:0]) >>> ins[24:20]); end
      end
      7'h33: begin
        e.wen = 1; e.sel = 2'b00; e.use_rs1 = 1; e.use_rs2 = 1; ok = 1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: e.res = a + b;
            3'd1: begin e.opt = 5'd2; e.res = a << b[5:0]; end
            3'd2: begin e.opt = 5'd3; e.res = {63'd0, $signed(a) < $signed(b)}; end
            3'd3: begin e.opt = 5'd4; e.res = {63'd0, a < b}; end
            3'd4: begin e.opt = 5'd5; e.res = a ^ b; end
            3'd5: begin e.opt = 5'd6; e.res = a >> b[5:0]; end
            3'd6: begin e.opt = 5'd8; e.res = a | b; end
            default: begin e.opt = 5'd9; e.res = a & b; end
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin e.opt = 5'd1; e.res = a - b; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.opt = 5'd7; e.res = $signed(a) >>> b[5:0]; end
        else ok = 0;
      end
      7'h3b: begin
        e.wen = 1; e.sel = 2'b00; e.use_rs1 = 1; e.use_rs2 = 1;
        if (f3 == 3'd0 && f7 == 7'h00) begin ok = 1; e.opt = 5'd10; e.res = sx32(a[31:0] + b[31:0]); end
        else if (f3 == 3'd0 && f7 == 7'h20) begin ok = 1; e.opt = 5'd11; e.res = sx32(a[31:0] - b[31:0]); end
        else if (f3 == 3'd1 && f7 == 7'h00) begin ok = 1; e.opt = 5'd12; e.res = sx32(a[31:0] << b[4:0]); end
        else if (f3 == 3'd5 && f7 == 7'h00) begin ok = 1; e.opt = 5'd13; e.res = sx32(a[31:0] >> b[4:0]); end
        else if (f3 == 3'd5 && f7 == 7'h20) begin ok = 1; e.opt = 5'd14; e.res = sx32(int'(a[31:0]) >>> b[4:0]); end
      end
      7'h73: if (ins == 32'h0010_0073) begin ok = 1; e.ebreak = 1; e.chk_imm_res = 0; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '{rd: 5'd0, rs1: 5'd0, rs2: 5'd0, use_rs1: 1, use_rs2: 1, chk_imm_res: 1,
            wen: 0, brch: 0, jal: 0, jalr: 0, ebreak: 0, illegal: 1,
            imm: 64'd0, res: 64'd0, sel: 2'b01, opt: 5'd0, lsu: 5'b00001};
    end
    return e;
  endfunction

  task automatic check_all(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    e = model(ins, pc);
    chk("ins", o_ins, ins);
    chk("imem_addr", o_imem_addr, pc);
    chk("illegal", o_illegal, e.illegal);
    chk("ebreak", o_ebreak, e.ebreak);
    chk("rdwen", o_rdwen, e.wen);
    chk("brch", o_brch, e.brch);
    chk("jal", o_jal, e.jal);
    chk("jalr", o_jalr, e.jalr);
    chk("lsu_opt", o_lsu_opt, e.lsu);
    if (e.wen || e.illegal) chk("rdid", o_rdid, e.rd);
    if (e.use_rs1) chk("rs1id", o_rs1id, e.rs1);
    if (e.use_rs2) chk("rs2id", o_rs2id, e.rs2);
    if (e.chk_imm_res) begin
      chk("sel", o_exu_src_sel, e.sel);
      chk("opt", o_exu_opt, e.opt);
      chk("imm", o_imm, e.imm);
      chk("res", o_exu_res, e.res);
      chk("zero", o_zero, (e.res == 64'd0));
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc);
    @(posedge clk);
    #1;
    i_imem_rdata = ins;
    i_pc = pc;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    rst = 1'b1; i_pc = 64'd0; i_imem_rdata = 32'hFFFF_FFFF;

    // Reset: two edges with all-ones memory data, NOP must be issued
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_all(32'h0000_0013, 64'd0);
    chk("rst_illegal", o_illegal, 1'b0);
    chk("rst_zero", o_zero, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rel_nop", o_ins, 32'h0000_0013);
    @(posedge clk); @(negedge clk);
    chk("pass_ins", o_ins, 32'hFFFF_FFFF);
    chk("pass_illegal", o_illegal, 1'b1);
    chk("pass_rdwen", o_rdwen, 1'b0);

    // addi x1,x0,-1
    drive(32'hFFF0_0093, 64'h1000);
    check_all(32'hFFF0_0093, 64'h1000);
    chk("addi_res", o_exu_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rdid", o_rdid, 5'd1);

    // beq x1,x2 taken / not taken
    rf[1] = 64'd5; rf[2] = 64'd5;
    drive(32'h0020_8463, 64'h2000);
    check_all(32'h0020_8463, 64'h2000);
    chk("beq_zero_taken", o_zero, 1'b1);
    chk("beq_opt", o_exu_opt, 5'd15);
    rf[2] = 64'd6; #1;
    chk("beq_zero_not", o_zero, 1'b0);

    // addw overflow sign-extension
    rf[1] = 64'h7FFF_FFFF; rf[2] = 64'd1;
    drive(32'h0020_81BB, 64'h3000);
    check_all(32'h0020_81BB, 64'h3000);
    chk("addw_res", o_exu_res, 64'hFFFF_FFFF_8000_0000);

    // ld / sd address generation
    rf[6] = 64'h8000_0000;
    drive(32'h0083_3283, 64'h4000);
    check_all(32'h0083_3283, 64'h4000);
    chk("ld_res", o_exu_res, 64'h8000_0008);
    chk("ld_lsu0", o_lsu_opt[0], 1'b0);
    drive(32'h0053_3423, 64'h4004);
    check_all(32'h0053_3423, 64'h4004);
    chk("sd_lsu1", o_lsu_opt[1], 1'b1);
    chk("sd_rdwen", o_rdwen, 1'b0);

    // jal and ebreak
    drive(32'h0100_00EF, 64'h8000_0000);
    check_all(32'h0100_00EF, 64'h8000_0000);
    chk("jal_imm", o_imm, 64'd16);
    chk("jal_res", o_exu_res, 64'h8000_0004);
    drive(32'h0010_0073, 64'h5000);
    check_all(32'h0010_0073, 64'h5000);
    chk("ebreak_flag", o_ebreak, 1'b1);

    // Randomized words, biased toward valid opcodes and funct7 patterns
    for (int n = 0; n < 800; n++) begin
      int r;
      ins = $urandom;
      r = $urandom_range(0, 15);
      if (r < 12) ins[6:0] = OPCS[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 0) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (r == 12) ins = 32'h0010_0073;
      pc = {$urandom, $urandom} & ~64'd3;
      for (int k = 1; k < 32; k++) rf[k] = {$urandom, $urandom};
      if (r == 13 && ins[19:15] != 5'd0) rf[ins[19:15]] = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0 && ins[24:20] != 5'd0) rf[ins[24:20]] = rf[ins[19:15]];
      drive(ins, pc);
      check_all(ins, pc);
    end

    // Reset mid-operation: the next edge brings the NOP back
    rf[1] = 64'h7FFF_FFFF; rf[2] = 64'd1;
    drive(32'h0020_81BB, 64'h3000);
    #1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_nop", o_ins, 32'h0000_0013);
    chk("midrst_res", o_exu_res, 64'd0);
    #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_resume", o_ins, 32'h0020_81BB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
